// File: rtl/door_access_ctrl.sv
// Door access sequencer around the serial-password lock core.
// Holds the core in reset until a user request, grants one attempt, then
// opens the door for a timed window on success or counts the failure and
// enforces a timed lockout (with a one-cycle alarm) when the limit is hit.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | core held in reset, waiting for start
//   S_WAIT    | core released, waiting for unlock/error or response timeout
//   S_OPEN    | door actuator enabled for OPEN_CYC cycles
//   S_LOCKOUT | attempts blocked for LOCK_CYC cycles after MAX_FAIL failures
module door_access_ctrl #(
    parameter int MAX_FAIL = 3,
    parameter int OPEN_CYC = 50,
    parameter int LOCK_CYC = 1000,
    parameter int RESP_TO  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       core_unlock,
    input  logic       core_error,
    output logic       core_rst,
    output logic       door_open,
    output logic       locked_out,
    output logic       alarm,
    output logic       busy,
    output logic [2:0] fail_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  fail_q, fail_d;
    logic [3:0]  fail_inc;
    logic        fail_evt;

    logic core_rst_q, core_rst_d;
    logic door_q, door_d;
    logic lock_q, lock_d;
    logic alarm_q, alarm_d;
    logic busy_q, busy_d;

    // State, timer, failure counter and all outputs are registered together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            fail_q     <= 3'd0;
            core_rst_q <= 1'b1;
            door_q     <= 1'b0;
            lock_q     <= 1'b0;
            alarm_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            core_rst_q <= core_rst_d;
            door_q     <= door_d;
            lock_q     <= lock_d;
            alarm_q    <= alarm_d;
            busy_q     <= busy_d;
        end
    end

    // Next state, timer and failure count; a core error outranks a same-cycle unlock
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        fail_evt = 1'b0;
        fail_inc = {1'b0, fail_q} + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    timer_d = 16'(RESP_TO);
                end
            end
            S_WAIT: begin
                if (core_error) begin
                    fail_evt = 1'b1;
                end else if (core_unlock) begin
                    state_d = S_OPEN;
                    fail_d  = 3'd0;
                    timer_d = 16'(OPEN_CYC);
                end else if (timer_q <= 16'd1) begin
                    fail_evt = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_OPEN: begin
                if (timer_q <= 16'd1) begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_LOCKOUT: begin
                if (timer_q <= 16'd1) begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                    fail_d  = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
        endcase

        // Failure outcome: lockout when the limit is reached, else back to idle
        if (fail_evt) begin
            if (fail_inc == 4'(MAX_FAIL)) begin
                state_d = S_LOCKOUT;
                fail_d  = 3'(MAX_FAIL);
                timer_d = 16'(LOCK_CYC);
            end else begin
                state_d = S_IDLE;
                fail_d  = fail_inc[2:0];
                timer_d = 16'd0;
            end
        end
    end

    // Next output values derived from the next state so outputs align with it
    always_comb begin
        core_rst_d = (state_d != S_WAIT);
        door_d     = (state_d == S_OPEN);
        lock_d     = (state_d == S_LOCKOUT);
        alarm_d    = (state_d == S_LOCKOUT) && (state_q != S_LOCKOUT);
        busy_d     = (state_d != S_IDLE);
    end

    assign core_rst   = core_rst_q;
    assign door_open  = door_q;
    assign locked_out = lock_q;
    assign alarm      = alarm_q;
    assign busy       = busy_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Bench for door_access_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a countdown-based model of the door rules.
module tb_door_access_ctrl;

    localparam int MAX_FAIL = 3;
    localparam int OPEN_CYC = 5;
    localparam int LOCK_CYC = 20;
    localparam int RESP_TO  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       core_unlock = 1'b0;
    logic       core_error = 1'b0;
    logic       core_rst;
    logic       door_open;
    logic       locked_out;
    logic       alarm;
    logic       busy;
    logic [2:0] fail_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: remaining cycles of each activity, zero when not active
    int  wait_left = 0;
    int  open_left = 0;
    int  lock_left = 0;
    int  fails = 0;
    bit  alarm_m = 1'b0;

    door_access_ctrl #(
        .MAX_FAIL(MAX_FAIL),
        .OPEN_CYC(OPEN_CYC),
        .LOCK_CYC(LOCK_CYC),
        .RESP_TO (RESP_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_unlock(core_unlock),
        .core_error (core_error),
        .core_rst   (core_rst),
        .door_open  (door_open),
        .locked_out (locked_out),
        .alarm      (alarm),
        .busy       (busy),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("core_rst",   {7'd0, core_rst},   {7'd0, (wait_left == 0)});
        chk("door_open",  {7'd0, door_open},  {7'd0, (open_left > 0)});
        chk("locked_out", {7'd0, locked_out}, {7'd0, (lock_left > 0)});
        chk("alarm",      {7'd0, alarm},      {7'd0, alarm_m});
        chk("busy",       {7'd0, busy},       {7'd0, (wait_left + open_left + lock_left > 0)});
        chk("fail_cnt",   {5'd0, fail_cnt},   8'(fails));
    endtask

    task automatic model_reset();
        wait_left = 0; open_left = 0; lock_left = 0; fails = 0; alarm_m = 1'b0;
    endtask

    // One clock of the door rules applied to the inputs seen at the edge
    task automatic model_edge(input bit s, input bit u, input bit e);
        alarm_m = 1'b0;
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (open_left > 0) begin
            open_left--;
        end else if (wait_left > 0) begin
            if (e || (!u && wait_left == 1)) begin
                wait_left = 0;
                fails++;
                if (fails == MAX_FAIL) begin
                    lock_left = LOCK_CYC;
                    alarm_m = 1'b1;
                end
            end else if (u) begin
                wait_left = 0;
                fails = 0;
                open_left = OPEN_CYC;
            end else begin
                wait_left--;
            end
        end else if (s) begin
            wait_left = RESP_TO;
        end
    endtask

    // Inputs are driven at the falling edge, consumed at the rising edge, checked at the next falling edge
    task automatic step(input bit s, input bit u, input bit e);
        start = s; core_unlock = u; core_error = e;
        @(posedge clk);
        model_edge(s, u, e);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Start an attempt and deliver the core result 8 cycles after release
    task automatic attempt(input bit u, input bit e);
        step(1'b1, 1'b0, 1'b0);
        idle(7);
        step(1'b0, u, e);
    endtask

    initial begin
        // Reset values
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Successful attempt: door open exactly OPEN_CYC cycles
        attempt(1'b1, 1'b0);
        idle(OPEN_CYC + 2);

        // Three errors: lockout with alarm, stray start/unlock ignored during lockout
        attempt(1'b0, 1'b1);
        attempt(1'b0, 1'b1);
        attempt(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        idle(LOCK_CYC);

        // Two failures then success resets count; a later failure gives count 1
        attempt(1'b0, 1'b1);
        attempt(1'b0, 1'b1);
        attempt(1'b1, 1'b0);
        idle(OPEN_CYC);
        attempt(1'b0, 1'b1);

        // Response timeout after RESP_TO cycles in WAIT
        step(1'b1, 1'b0, 1'b0);
        idle(RESP_TO + 1);

        // Unlock and error together count as a failure, reaching lockout
        attempt(1'b1, 1'b1);
        idle(LOCK_CYC + 1);

        // Core pulses outside WAIT have no effect
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the open window
        attempt(1'b1, 1'b0);
        idle(2);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
